// File: rtl/nn_pkg.sv
// Shared constants and types for the neural-network weight path.
// Used by the F_node weight loader and its staging bank.
package nn_pkg;

    localparam int NUM_OUT  = 16;
    localparam int WEIGHT_W = 5;
    localparam int IDX_W    = $clog2(NUM_OUT);

    typedef logic [WEIGHT_W-1:0] weight_t;
    typedef logic [IDX_W-1:0]    idx_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2
    } state_t;

    localparam idx_t LAST_IDX = idx_t'(NUM_OUT - 1);

endpackage

// File: rtl/weight_bank.sv
// Staging register with indexed write, plus a parallel copy into the
// output bank on commit so downstream never sees a partially loaded bank.
module weight_bank
    import nn_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  idx_t                         wr_idx,
    input  weight_t                      wr_data,
    input  logic                         commit,
    output logic [NUM_OUT*WEIGHT_W-1:0]  bank
);

    weight_t [NUM_OUT-1:0] staging;
    weight_t [NUM_OUT-1:0] staging_next;

    // The commit beat also carries the last weight, so the copy takes the
    // merged value rather than the registered staging contents.
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        staging_next = staging;
        if (wr_en) begin
            staging_next[wr_idx] = wr_data;
        end
    end

    // NOTE: this bank is small register storage, so it is reset like any
    // other flop; a RAM-style array would normally be left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staging <= '0;
            bank    <= '0;
        end else begin
            staging <= staging_next;
            if (commit) begin
                bank <= staging_next;
            end
        end
    end

endmodule

// File: rtl/f_node_loader.sv
// Serial-to-parallel weight loader: collects NUM_OUT beats over valid/ready
// and presents the full bank to F_node with a single-cycle write strobe.
module f_node_loader
    import nn_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [WEIGHT_W-1:0]          s_weight,
    input  logic                         s_last,
    output logic                         write_enable,
    output logic [NUM_OUT*WEIGHT_W-1:0]  write_in,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    state_t state_q;
    state_t state_next;
    idx_t   idx_q;
    logic   err_q;

    logic accept;
    logic final_beat;
    logic commit;
    logic bad_last;

    assign accept     = s_valid && (state_q == COLLECT);
    assign final_beat = (idx_q == LAST_IDX);
    assign commit     = accept && final_beat && s_last;
    // A misplaced s_last covers both early last and missing last.
    assign bad_last   = accept && (s_last != final_beat);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin
        state_next = state_q;
        unique case (state_q)
            IDLE:    if (start) state_next = COLLECT;
            COLLECT: begin
                if (commit) begin
                    state_next = WRITE;
                end else if (bad_last) begin
                    state_next = IDLE;
                end
            end
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        s_ready      = (state_q == COLLECT);
        busy         = (state_q == COLLECT) || (state_q == WRITE);
        write_enable = (state_q == WRITE);
        done         = (state_q == WRITE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= bad_last;
            if (state_q == IDLE && start) begin
                idx_q <= '0;
            end else if (accept) begin
                idx_q <= (s_last || final_beat) ? '0 : idx_q + 1'b1;
            end
        end
    end

    assign err = err_q;

    weight_bank u_weight_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (accept),
        .wr_idx  (idx_q),
        .wr_data (s_weight),
        .commit  (commit),
        .bank    (write_in)
    );

endmodule

// File: tb/tb_f_node_loader.sv
// Self-checking bench for f_node_loader: directed test-plan loads followed
// by randomized loads, checked against a load-level reference model.
module tb_f_node_loader;
    import nn_pkg::*;

    logic                        clk;
    logic                        rst_n;
    logic                        start;
    logic                        s_valid;
    logic                        s_ready;
    logic [WEIGHT_W-1:0]         s_weight;
    logic                        s_last;
    logic                        write_enable;
    logic [NUM_OUT*WEIGHT_W-1:0] write_in;
    logic                        busy;
    logic                        done;
    logic                        err;

    int n_compared;
    int n_mismatched;

    // Reference: the bank F_node should currently hold.
    weight_t model_bank[NUM_OUT];

    f_node_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_weight     (s_weight),
        .s_last       (s_last),
        .write_enable (write_enable),
        .write_in     (write_in),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NUM_OUT*WEIGHT_W-1:0] expected_bank();
        logic [NUM_OUT*WEIGHT_W-1:0] v;
        for (int k = 0; k < NUM_OUT; k++) v[k*WEIGHT_W +: WEIGHT_W] = model_bank[k];
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // last_beat: 1..16 places s_last on that beat, 0 never drives it.
    // stall: 0 always valid, 1 valid every other cycle, 2 random valid/start.
    // abort_after: nonzero asserts reset once that many beats are accepted.
    task automatic run_load(input weight_t w[NUM_OUT], input int last_beat,
                            input int stall, input int abort_after);
        int   n;
        int   cyc;
        logic v;
        logic lst;
        logic finished;
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_s_ready", s_ready, 1);
        check("start_busy", busy, 1);
        n = 0;
        cyc = 0;
        finished = 1'b0;
        while (!finished) begin
            case (stall)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            lst      = (n + 1 == last_beat);
            s_valid  = v;
            s_weight = w[n];
            s_last   = lst;
            if (stall == 2) start = ($urandom_range(0, 3) == 0);
            step();
            cyc++;
            s_valid = 1'b0;
            s_last  = 1'b0;
            start   = 1'b0;
            if (v) n++;
            if (v && abort_after != 0 && n == abort_after) begin
                rst_n = 1'b0;
                #2;
                for (int k = 0; k < NUM_OUT; k++) model_bank[k] = '0;
                check("abort_write_in", write_in, expected_bank());
                check("abort_outputs", {s_ready, write_enable, busy, done, err}, 5'b0);
                @(posedge clk);
                #3;
                rst_n = 1'b1;
                finished = 1'b1;
            end else if (v && lst && n == NUM_OUT) begin
                for (int k = 0; k < NUM_OUT; k++) model_bank[k] = w[k];
                check("wr_strobe", {write_enable, done, err, s_ready, busy}, 5'b11001);
                check("wr_write_in", write_in, expected_bank());
                step();
                check("wr_after", {write_enable, done, busy, s_ready}, 4'b0);
                check("wr_hold", write_in, expected_bank());
                finished = 1'b1;
            end else if (v && (lst || n == NUM_OUT)) begin
                check("err_pulse", {err, s_ready, write_enable, done}, 4'b1000);
                check("err_write_in", write_in, expected_bank());
                step();
                check("err_after", {err, busy, write_enable}, 3'b0);
                finished = 1'b1;
            end else begin
                check("collect", {s_ready, busy, write_enable, done, err}, 5'b11000);
            end
            if (!finished && cyc > 400) begin
                check("load_timeout", 1, 0);
                finished = 1'b1;
            end
        end
    endtask

    weight_t nominal[NUM_OUT];
    weight_t other[NUM_OUT];
    weight_t ones[NUM_OUT];

    initial begin
        int last_beat;
        n_compared   = 0;
        n_mismatched = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        s_valid  = 1'b0;
        s_weight = '0;
        s_last   = 1'b0;
        for (int k = 0; k < NUM_OUT; k++) model_bank[k] = '0;
        nominal = '{5'b10101, 5'b10001, 5'b10010, 5'b10011, 5'b10100, 5'b10110,
                    5'b10111, 5'b11000, 5'b11001, 5'b11010, 5'b11011, 5'b11100,
                    5'b11101, 5'b11110, 5'b11111, 5'b10000};
        for (int k = 0; k < NUM_OUT; k++) begin
            other[k] = weight_t'(k + 3);
            ones[k]  = 5'b11111;
        end

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {s_ready, write_enable, busy, done, err}, 5'b0);
        check("rst_write_in", write_in, '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_no_start", {s_ready, busy}, 2'b0);
        end

        // Nominal, stalled, early last, missing last.
        run_load(nominal, 16, 0, 0);
        check("nominal_slot0", write_in[0 +: WEIGHT_W], 5'b10101);
        check("nominal_slot15", write_in[15*WEIGHT_W +: WEIGHT_W], 5'b10000);
        run_load(nominal, 16, 1, 0);
        run_load(other, 8, 0, 0);
        run_load(other, 0, 0, 0);
        check("kept_nominal", write_in, expected_bank());

        // Mid-load reset, then a fresh all-ones load.
        run_load(other, 16, 0, 10);
        run_load(ones, 16, 0, 0);
        check("all_ones", write_in, {NUM_OUT*WEIGHT_W{1'b1}});

        // Back-to-back: start sampled on the cycle right after the write.
        run_load(other, 16, 0, 0);
        run_load(nominal, 16, 0, 0);

        // Randomized loads with stalls, stray starts and misplaced lasts.
        for (int t = 0; t < 40; t++) begin
            weight_t rw[NUM_OUT];
            for (int k = 0; k < NUM_OUT; k++) rw[k] = weight_t'($urandom);
            last_beat = ($urandom_range(0, 9) < 7) ? 16 : int'($urandom_range(0, 15));
            run_load(rw, last_beat, 2, 0);
            repeat ($urandom_range(0, 2)) begin
                step();
                check("rand_idle", {s_ready, busy, err, write_enable}, 4'b0);
            end
        end
        check("final_bank", write_in, expected_bank());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
